// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, load/store size codes
// and the alignment rule used to reject misaligned requests.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;

   localparam logic [1:0] FNC_SB = 2'b00;
   localparam logic [1:0] FNC_SH = 2'b01;
   localparam logic [1:0] FNC_SW = 2'b10;

   // Bits [1:0] carry the access width for both loads and stores; unknown codes act as a word.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
      logic mis;
      case (size[1:0])
         FNC_SB:  mis = 1'b0;
         FNC_SH:  mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane alignment: stores produce a byte mask and lane-shifted data; loads pick the
// addressed byte/half out of a word and sign- or zero-extend it.
module dmem_responder_mem_lane_align
   import dmem_responder_pkg::*;
#(
   parameter bit LOAD = 1'b0
) (
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] din,
   output logic [3:0]  mask,
   output logic [31:0] dout
);

   generate
      if (LOAD) begin : g_load
         logic [7:0]  byte_sel;
         logic [15:0] half_sel;

         assign byte_sel = din[{off, 3'b000} +: 8];
         assign half_sel = din[{off[1], 4'b0000} +: 16];
         // Reads always fetch the whole word.
         assign mask     = 4'b1111;

         always_comb begin
            dout = din;
            case (size)
               FNC_LB:  dout = {{24{byte_sel[7]}}, byte_sel};
               FNC_LH:  dout = {{16{half_sel[15]}}, half_sel};
               FNC_LBU: dout = {24'd0, byte_sel};
               FNC_LHU: dout = {16'd0, half_sel};
               FNC_LW:  dout = din;
               default: dout = din;
            endcase
         end
      end else begin : g_store
         always_comb begin
            mask = 4'b1111;
            dout = din;
            casez (size)
               {1'b?, FNC_SB}: begin
                  mask = 4'b0001 << off;
                  dout = {24'd0, din[7:0]} << {off, 3'b000};
               end
               {1'b?, FNC_SH}: begin
                  mask = 4'b0011 << {off[1], 1'b0};
                  dout = {16'd0, din[15:0]} << {off[1], 4'b0000};
               end
               {1'b?, FNC_SW}: begin
                  mask = 4'b1111;
                  dout = din;
               end
               default: begin
                  mask = 4'b1111;
                  dout = din;
               end
            endcase
         end
      end
   endgenerate

endmodule

// File: rtl/dmem_responder.sv
// M-stage data-memory responder: direct-mapped write-through, no-write-allocate cache with
// one word per line, fronting a valid/ready backing memory.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int LINES  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misaligned,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-3:0] mem_req_addr,
   output logic [31:0]       mem_req_data,
   output logic [3:0]        mem_req_mask,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data
);

   localparam int IDX_W = $clog2(LINES);
   localparam int WA_W  = ADDR_W - 2;
   localparam int TAG_W = WA_W - IDX_W;

   state_e            state_q, state_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [31:0]       data_q [LINES];
   logic [31:0]       data_d [LINES];

   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              misaligned_q, misaligned_d;
   logic              mem_rw_q, mem_rw_d;
   logic [WA_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]       mem_data_q, mem_data_d;
   logic [3:0]        mem_mask_q, mem_mask_d;
   logic [2:0]        sv_size_q, sv_size_d;
   logic [1:0]        sv_off_q, sv_off_d;

   logic [IDX_W-1:0]  req_idx, fill_idx;
   logic [TAG_W-1:0]  req_tag, fill_tag;
   logic              in_idle, hit, mis;
   logic [3:0]        st_mask, rd_mask;
   logic [31:0]       st_data, ld_data, ld_word;
   logic [2:0]        ld_size;
   logic [1:0]        ld_off;

   assign req_idx  = req_addr[IDX_W+1:2];
   assign req_tag  = req_addr[ADDR_W-1:IDX_W+2];
   // The outstanding word address doubles as the fill location once data returns.
   assign fill_idx = mem_addr_q[IDX_W-1:0];
   assign fill_tag = mem_addr_q[WA_W-1:IDX_W];
   assign in_idle  = (state_q == ST_IDLE);
   assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   assign mis      = is_misaligned(req_size, req_addr[1:0]);

   // Hits extend the cached word at accept; fills extend the returning word in WAIT.
   assign ld_size  = in_idle ? req_size       : sv_size_q;
   assign ld_off   = in_idle ? req_addr[1:0]  : sv_off_q;
   assign ld_word  = in_idle ? data_q[req_idx] : mem_resp_data;

   dmem_responder_mem_lane_align #(.LOAD(1'b0)) u_store_align (
      .size (req_size),
      .off  (req_addr[1:0]),
      .din  (req_wdata),
      .mask (st_mask),
      .dout (st_data)
   );

   dmem_responder_mem_lane_align #(.LOAD(1'b1)) u_load_align (
      .size (ld_size),
      .off  (ld_off),
      .din  (ld_word),
      .mask (rd_mask),
      .dout (ld_data)
   );

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'd0;
      misaligned_d = 1'b0;
      mem_rw_d     = mem_rw_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_mask_d   = mem_mask_q;
      sv_size_d    = sv_size_q;
      sv_off_d     = sv_off_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (mis) begin
                  misaligned_d = 1'b1;
                  resp_valid_d = !req_we;
               end else if (req_we) begin
                  state_d    = ST_FETCH;
                  mem_rw_d   = 1'b1;
                  mem_addr_d = req_addr[ADDR_W-1:2];
                  mem_data_d = st_data;
                  mem_mask_d = st_mask;
                  // Write-through keeps a resident line coherent; misses do not allocate.
                  if (hit) begin
                     for (int b = 0; b < 4; b++) begin
                        if (st_mask[b]) data_d[req_idx][8*b +: 8] = st_data[8*b +: 8];
                     end
                  end
               end else if (hit) begin
                  resp_valid_d = 1'b1;
                  resp_rdata_d = ld_data;
               end else begin
                  state_d    = ST_FETCH;
                  mem_rw_d   = 1'b0;
                  mem_addr_d = req_addr[ADDR_W-1:2];
                  mem_data_d = 32'd0;
                  mem_mask_d = rd_mask;
                  sv_size_d  = req_size;
                  sv_off_d   = req_addr[1:0];
               end
            end
         end
         ST_FETCH: begin
            if (mem_req_ready) state_d = mem_rw_q ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               state_d            = ST_RESP;
               valid_d[fill_idx]  = 1'b1;
               tag_d[fill_idx]    = fill_tag;
               data_d[fill_idx]   = mem_resp_data;
               resp_valid_d       = 1'b1;
               resp_rdata_d       = ld_data;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         valid_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         misaligned_q <= 1'b0;
         mem_rw_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= 32'd0;
         mem_mask_q   <= 4'd0;
         sv_size_q    <= 3'd0;
         sv_off_q     <= 2'd0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         misaligned_q <= misaligned_d;
         mem_rw_q     <= mem_rw_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_mask_q   <= mem_mask_d;
         sv_size_q    <= sv_size_d;
         sv_off_q     <= sv_off_d;
      end
   end

   // Line contents are qualified by valid_q, so they need no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign stall = reset && (((state_q != ST_IDLE) && (state_q != ST_RESP)) ||
                            (in_idle && req_valid && (req_we || !hit) && !mis));

   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;
   assign misaligned    = misaligned_q;
   assign mem_req_valid = (state_q == ST_FETCH);
   assign mem_req_rw    = mem_rw_q;
   assign mem_req_addr  = mem_addr_q;
   assign mem_req_data  = mem_data_q;
   assign mem_req_mask  = mem_mask_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder against a word-level memory model
// plus a record of which word address each cache index currently holds.
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int LINES  = 64;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_we = 1'b0;
   logic [2:0]        req_size = 3'd0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = 32'd0;
   logic              stall;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              misaligned;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic              mem_req_rw;
   logic [ADDR_W-3:0] mem_req_addr;
   logic [31:0]       mem_req_data;
   logic [3:0]        mem_req_mask;
   logic              mem_resp_valid = 1'b0;
   logic [31:0]       mem_resp_data = 32'd0;

   dmem_responder #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .misaligned     (misaligned),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rw     (mem_req_rw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_req_mask   (mem_req_mask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;

   logic [31:0] mem_model [int];
   bit          cvalid [LINES];
   int          cword  [LINES];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input int wa);
      if (!mem_model.exists(wa)) mem_model[wa] = $urandom;
      return mem_model[wa];
   endfunction

   function automatic int req_bytes(input logic [2:0] sz);
      if (sz[1:0] == 2'd0) return 1;
      if (sz[1:0] == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] sz, input int off);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (8 * ((off / 2) * 2))) & 32'hFFFF;
      case (sz)
         3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic run_req(input bit we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdly_in, input int wdly_in,
                          output logic [31:0] rdata, output logic [3:0] mask_o,
                          output logic [31:0] data_o);
      int          wa, idx, off, nb, rdly, wdly;
      bit          hit, mis;
      longint      smask, sdata;
      logic [31:0] exp_ld, w;
      wa     = int'(addr >> 2);
      idx    = wa % LINES;
      off    = int'(addr % 4);
      nb     = req_bytes(sz);
      mis    = (off % nb) != 0;
      hit    = cvalid[idx] && (cword[idx] == wa);
      smask  = ((longint'(1) << nb) - 1) << off;
      sdata  = (longint'(wd) & ((longint'(1) << (8 * nb)) - 1)) << (8 * off);
      exp_ld = ext_load(mem_word(wa), sz, off);
      rdly   = (rdly_in < 0) ? int'($urandom_range(0, 3)) : rdly_in;
      wdly   = (wdly_in < 0) ? int'($urandom_range(0, 4)) : wdly_in;
      rdata  = 32'd0;
      mask_o = 4'd0;
      data_o = 32'd0;

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
      #1;
      chk("stall_accept", 32'(stall), 32'(!mis && (we || !hit)));
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;

      if (mis) begin
         chk("mis_flag", 32'(misaligned), 32'd1);
         chk("mis_resp_valid", 32'(resp_valid), 32'(!we));
         chk("mis_rdata", resp_rdata, 32'd0);
         chk("mis_no_memreq", 32'(mem_req_valid), 32'd0);
         @(posedge clk); #1;
         chk("mis_pulse_end", 32'(misaligned), 32'd0);
         chk("mis_resp_end", 32'(resp_valid), 32'd0);
      end else if (!we && hit) begin
         chk("hit_resp_valid", 32'(resp_valid), 32'd1);
         chk("hit_rdata", resp_rdata, exp_ld);
         chk("hit_no_memreq", 32'(mem_req_valid), 32'd0);
         chk("hit_no_stall", 32'(stall), 32'd0);
         rdata = resp_rdata;
         @(posedge clk); #1;
         chk("hit_resp_end", 32'(resp_valid), 32'd0);
      end else begin
         chk("fetch_valid", 32'(mem_req_valid), 32'd1);
         chk("fetch_rw", 32'(mem_req_rw), 32'(we));
         chk("fetch_addr", 32'(mem_req_addr), 32'(wa));
         chk("fetch_mask", 32'(mem_req_mask), we ? 32'(smask) : 32'hF);
         if (we) chk("fetch_data", mem_req_data, 32'(sdata));
         mask_o = mem_req_mask;
         data_o = mem_req_data;
         repeat (rdly) begin
            @(negedge clk);
            mem_req_ready = 1'b0; mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = $urandom;
            #1;
            chk("fetch_stall", 32'(stall), 32'd1);
         end
         @(negedge clk);
         mem_req_ready = 1'b1; mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = $urandom;
         #1;
         chk("fetch_hold_valid", 32'(mem_req_valid), 32'd1);
         chk("fetch_hold_addr", 32'(mem_req_addr), 32'(wa));
         chk("fetch_hold_mask", 32'(mem_req_mask), 32'(mask_o));
         @(posedge clk); #1;
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         if (we) begin
            w = mem_word(wa);
            for (int b = 0; b < 4; b++) begin
               if (smask[b]) w[8*b +: 8] = sdata[8*b +: 8];
            end
            mem_model[wa] = w;
            chk("store_done_valid", 32'(mem_req_valid), 32'd0);
            chk("store_done_stall", 32'(stall), 32'd0);
            chk("store_no_resp", 32'(resp_valid), 32'd0);
         end else begin
            repeat (wdly) begin
               @(negedge clk);
               chk("wait_stall", 32'(stall), 32'd1);
               chk("wait_no_memreq", 32'(mem_req_valid), 32'd0);
               chk("wait_no_resp", 32'(resp_valid), 32'd0);
            end
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_data = mem_word(wa);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0; mem_resp_data = $urandom;
            chk("fill_resp_valid", 32'(resp_valid), 32'd1);
            chk("fill_rdata", resp_rdata, exp_ld);
            chk("fill_no_stall", 32'(stall), 32'd0);
            rdata = resp_rdata;
            cvalid[idx] = 1'b1;
            cword[idx]  = wa;
            @(posedge clk); #1;
            chk("fill_resp_end", 32'(resp_valid), 32'd0);
            chk("fill_rdata_zero", resp_rdata, 32'd0);
         end
      end
   endtask

   initial begin
      logic [31:0] rd, dd;
      logic [3:0]  mk;
      logic [2:0]  ld_codes [8];
      int          wa, off, nb;
      bit          we;
      logic [2:0]  sz;
      ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

      // Reset held with a request pending and memory ready.
      reset = 1'b0; mem_req_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_size = FNC_LW; req_addr = 32'h100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      req_valid = 1'b0; mem_req_ready = 1'b0;
      reset = 1'b1;

      mem_model[32'h40] = 32'hDEADBEEF;
      run_req(1'b0, FNC_LW, 32'h100, 32'd0, 0, 3, rd, mk, dd);
      chk("lw100_cold", rd, 32'hDEADBEEF);
      run_req(1'b0, FNC_LW, 32'h100, 32'd0, 0, 0, rd, mk, dd);
      chk("lw100_hit", rd, 32'hDEADBEEF);

      run_req(1'b0, FNC_LB, 32'h103, 32'd0, 0, 0, rd, mk, dd);
      chk("lb103", rd, 32'hFFFFFFDE);
      run_req(1'b0, FNC_LBU, 32'h103, 32'd0, 0, 0, rd, mk, dd);
      chk("lbu103", rd, 32'h000000DE);
      run_req(1'b0, FNC_LH, 32'h102, 32'd0, 0, 0, rd, mk, dd);
      chk("lh102", rd, 32'hFFFFDEAD);
      run_req(1'b0, FNC_LHU, 32'h100, 32'd0, 0, 0, rd, mk, dd);
      chk("lhu100", rd, 32'h0000BEEF);

      run_req(1'b1, {1'b0, FNC_SB}, 32'h101, 32'h55, 2, 0, rd, mk, dd);
      chk("sb101_mask", 32'(mk), 32'h2);
      chk("sb101_data", dd, 32'h00005500);
      run_req(1'b0, FNC_LW, 32'h100, 32'd0, 0, 0, rd, mk, dd);
      chk("lw100_merged", rd, 32'hDEAD55EF);

      run_req(1'b0, FNC_LH, 32'h101, 32'd0, 0, 0, rd, mk, dd);
      run_req(1'b1, {1'b0, FNC_SW}, 32'h102, 32'h12345678, 0, 0, rd, mk, dd);
      run_req(1'b0, FNC_LW, 32'h100, 32'd0, 0, 0, rd, mk, dd);
      chk("lw100_after_mis", rd, 32'hDEAD55EF);

      // Reset in the middle of a stuck fetch abandons it and empties the cache.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = FNC_LW; req_addr = 32'h204; mem_req_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stuck_fetch_valid", 32'(mem_req_valid), 32'd1);
      end
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_memreq", 32'(mem_req_valid), 32'd0);
      chk("async_rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < LINES; i++) cvalid[i] = 1'b0;
      run_req(1'b0, FNC_LW, 32'h100, 32'd0, 1, 1, rd, mk, dd);
      chk("lw100_after_reset", rd, 32'hDEAD55EF);

      for (int n = 0; n < 250; n++) begin
         we  = ($urandom_range(0, 2) == 0);
         wa  = ($urandom_range(0, 1) == 1 ? 64 : 0) + int'($urandom_range(0, 7));
         sz  = we ? {1'b0, 2'($urandom_range(0, 3))} : ld_codes[$urandom_range(0, 7)];
         nb  = req_bytes(sz);
         off = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) off = off - (off % nb);
         run_req(we, sz, 32'(wa * 4 + off), $urandom, -1, -1, rd, mk, dd);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
